volume_recorder: RTL
====================

VOLUME_RECORDER -- requirements
Module: volume_recorder

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 4, meaning clk cycles between volume samples (range 1..65535).
REQ-002 SHALL have parameter DEPTH, fixed value 16, meaning number of history entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  record button level (btnC); rising edge arms, low level stops.
REQ-006 SHALL have port abort  input  1  synchronous return to IDLE (e.g. sw off).
REQ-007 SHALL have port volume  input  5  current mic volume sample.
REQ-008 SHALL have port rd_idx  input  4  renderer read index, 0 = newest.
REQ-009 SHALL have port rd_data  output  5  history entry at rd_idx.
REQ-010 SHALL have port count  output  5  valid entries, 0..16.
REQ-011 SHALL have port peak  output  5  maximum volume sampled in the current recording.
REQ-012 SHALL have port busy  output  1  high in CLEAR or RECORD.
REQ-013 SHALL have port done  output  1  high in HOLD.
REQ-014 SHALL have port state  output  2  IDLE=0, CLEAR=1, RECORD=2, HOLD=3.

Function
REQ-015 SHALL register start into start_q each cycle; start_rise = start & ~start_q.
REQ-016 SHALL implement an FSM with IDLE, CLEAR, RECORD and HOLD, encoded as in REQ-014.
REQ-017 IDLE SHALL go to CLEAR on start_rise; buffer, count and peak are held.
REQ-018 CLEAR SHALL last exactly one cycle: all 16 entries, count, peak and the divider go to 0; next state is RECORD.
REQ-019 RECORD SHALL increment the divider each cycle; sample tick = divider == SAMPLE_DIV-1, after which the divider goes to 0.
REQ-020 On a sample tick: entry[0] <= volume; entry[i] <= entry[i-1] for i = 1..15; entry[15] is discarded.
REQ-021 On a sample tick: count <= min(count+1, 16); peak <= max(peak, volume), unsigned 5-bit compare.
REQ-022 The first sample SHALL be taken SAMPLE_DIV cycles after entering RECORD.
REQ-023 RECORD SHALL go to HOLD when start == 0, or when a sample tick makes count reach 16.
REQ-024 When start == 0 coincides with a sample tick, the sample SHALL be taken and the FSM then enters HOLD.
REQ-025 HOLD SHALL freeze the buffer, count and peak; start_rise goes to CLEAR (re-record).
REQ-026 abort == 1 in any state SHALL force IDLE on the next edge, overriding every other transition.
REQ-027 abort SHALL leave buffer, count and peak unchanged, with no sample taken that cycle; the divider goes to 0.
REQ-028 rd_data SHALL be combinational entry[rd_idx], valid in every state.
REQ-029 A read in the same cycle as a shift SHALL return the pre-edge value.
REQ-030 busy and done SHALL be decoded combinationally from state.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, start_q=0, divider=0, count=0, peak=0 and all entries 0.
REQ-032 This reset SHALL act in any state, including mid-RECORD, with no sample stored.
REQ-033 Outputs during and after reset SHALL be: rd_data=0, busy=0, done=0.
REQ-034 start held high across reset release SHALL count as a rising edge in the first cycle after release.

Verification
REQ-035 Basic record: SAMPLE_DIV=4, start rises, volume=7 for 12 cycles, then start falls. Required: state 0->1->2; samples at cycles 4, 8 and 12 of RECORD; count=3; peak=7; entry[0..2]=7, entry[3]=0; done=1.
REQ-036 Saturation: start held, volume ramps 1,2,...,20 (one value per tick). Required: HOLD after the 16th tick; count=16; entry[0]=16, entry[15]=1; peak=16.
REQ-037 Coincidence: start falls on the exact tick cycle with volume=9. Required: entry[0]=9, count incremented, next state HOLD.
REQ-038 Abort mid-RECORD after 2 samples (5, 6). Required: state=IDLE next cycle; count=2; entry[0]=6, entry[1]=5 retained; a later start_rise clears all to 0.
REQ-039 Async reset: rst_n pulsed low mid-RECORD, between clock edges. Required: state=0, count=0, peak=0, rd_data=0 with no clock edge needed.
REQ-040 Re-record from HOLD: start_rise. Required: one CLEAR cycle with busy=1 and done=0; count=0 and peak=0 on the following cycle.

Source files
------------

// File: rtl/volume_recorder.sv
// Microphone volume history recorder: samples volume every SAMPLE_DIV cycles
// into a 16-entry newest-first history while the record button is held.
module volume_recorder #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] volume,
    input  logic [3:0] rd_idx,
    output logic [4:0] rd_data,
    output logic [4:0] count,
    output logic [4:0] peak,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int unsigned VOL_W = 5;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RECORD = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt;
    logic               start_q;
    logic [DIV_W-1:0]   div;
    logic [VOL_W-1:0]   entries [DEPTH];
    logic               start_rise;
    logic               tick;

    assign start_rise = start & ~start_q;
    assign tick       = (state_r == RECORD) && (div == DIV_W'(SAMPLE_DIV - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:   if (start_rise) state_nxt = CLEAR;
            CLEAR:  state_nxt = RECORD;
            RECORD: if (!start || (tick && count == CNT_W'(DEPTH - 1))) state_nxt = HOLD;
            HOLD:   if (start_rise) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // History buffer, sample count, peak and sample divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            div     <= '0;
            count   <= '0;
            peak    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else begin
            start_q <= start;
            if (abort) begin
                div <= '0;
            end else begin
                case (state_r)
                    CLEAR: begin
                        div   <= '0;
                        count <= '0;
                        peak  <= '0;
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            entries[i] <= '0;
                        end
                    end
                    RECORD: begin
                        if (tick) begin
                            div        <= '0;
                            entries[0] <= volume;
                            for (int i = 1; i < int'(DEPTH); i++) begin
                                entries[i] <= entries[i-1];
                            end
                            if (count != CNT_W'(DEPTH)) begin
                                count <= count + CNT_W'(1);
                            end
                            if (volume > peak) begin
                                peak <= volume;
                            end
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    default: div <= '0;
                endcase
            end
        end
    end

    assign rd_data = entries[rd_idx];
    assign busy    = (state_r == CLEAR) || (state_r == RECORD);
    assign done    = (state_r == HOLD);
    assign state   = state_r;

endmodule
